button_conditioner: RTL

- Input-conditioning stage between the raw Basys3 push-buttons (btnU/btnL/btnR/btnD) and the Pong core's ui_in[3:0].
- Per button: two-flop synchronisation, counter-based debounce, then a clean level plus one-cycle press/release pulses.
- The board top drives ui_in from `level` (or from `press` for step-mode tests) instead of from the raw pins.
- Runs in the core clock domain (50 MHz).

---
 rtl/button_pkg.sv | 26 ++
 rtl/debounce_channel.sv | 136 +++++++++++++
 rtl/button_conditioner.sv | 56 +++++
 3 files changed

// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared constants and width helpers for the push-button conditioning path.
// No ports; imported by debounce_channel and button_conditioner.
// -----------------------------------------------------------------------------
package button_pkg;

  localparam int CLK_HZ                  = 50000000;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;   // 10 ms at 50 MHz
  localparam int REPEAT_DELAY_DEFAULT    = 25000000; // 500 ms hold before first repeat
  localparam int REPEAT_PERIOD_DEFAULT   = 5000000;  // 100 ms between later repeats

  // Debounce counter width. Values run 0..n-1 and clear at the terminal
  // count, so $clog2(n) bits are enough. Never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Repeat counter width. Sized for the larger of the two reload targets.
  function automatic int rep_width(input int delay, input int period);
    int m;
    m = (delay > period) ? delay : period;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One button: two-flop synchroniser, counter debounce, registered level and
// one-cycle press / release pulses. Optional auto-repeat on press when the
// macro BUTTON_AUTO_REPEAT_EN is defined.
//
// Ports
//   clock      in   core clock, all state on the rising edge
//   reset      in   synchronous, active-high
//   btn_in     in   raw asynchronous button pin, active-high
//   level      out  debounced button state
//   press      out  one-cycle pulse on accepted 0->1 (and repeat pulses)
//   release_o  out  one-cycle pulse on accepted 1->0
//                   (named release_o because "release" is a reserved word)
// -----------------------------------------------------------------------------
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          accept, rise, fall;
  logic          rep_fire;

  // Debounce: any sample of s2 that agrees with the current level clears the
  // counter, so a single bounce restarts the whole window.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    accept  = 1'b0;
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
      accept  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise = accept &  s2_q;
  assign fall = accept & ~s2_q;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = rep_width(REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d; // 1 once the first repeat has fired
  logic [RW-1:0] rep_target;

  assign rep_target = rep_armed_q ? PERIOD_LAST : DELAY_LAST;

  // A rise cannot coincide with a repeat (level is still low) and a fall
  // clears the counter without firing, so press and release never overlap.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_armed_d = rep_armed_q;
    rep_fire    = 1'b0;
    if (rise || fall || !level_q) begin
      rep_cnt_d   = '0;
      rep_armed_d = 1'b0;
    end else if (rep_cnt_q == rep_target) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_armed_d = 1'b1;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Pulses are registered at the same edge that updates level, so each pulse
  // occupies the first cycle of the new level.
  always_comb begin
    press_d   = rise | rep_fire;
    release_d = fall;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_in;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions the raw board push-buttons for the Pong core: one independent
// debounce_channel per button. Optional auto-repeat is built in when the
// macro BUTTON_AUTO_REPEAT_EN is defined; otherwise press fires once per
// accepted press and no repeat logic exists.
//
// Ports
//   clock      in   core clock (50 MHz), single domain
//   reset      in   synchronous, active-high
//   btn_in     in   [N_BUTTONS] raw asynchronous pins, active-high
//   level      out  [N_BUTTONS] debounced registered state
//   press      out  [N_BUTTONS] one-cycle pulse per accepted press (+ repeats)
//   release_o  out  [N_BUTTONS] one-cycle pulse per accepted release
//                   (named release_o because "release" is a reserved word)
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_in,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  output logic [N_BUTTONS-1:0] release_o
);

  // Reject illegal parameter sets at elaboration.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_conditioner: illegal DEBOUNCE_CYCLES/REPEAT_DELAY/REPEAT_PERIOD");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_chan (
      .clock     (clock),
      .reset     (reset),
      .btn_in    (btn_in[i]),
      .level     (level[i]),
      .press     (press[i]),
      .release_o (release_o[i])
    );
  end

endmodule
